// File: rtl/time_set_ctrl_pkg.sv
// Shared types and limits for the time/alarm entry controller.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StLoad    = 2'd3
  } state_e;

  typedef enum logic {
    TgtTime  = 1'b0,
    TgtAlarm = 1'b1
  } target_e;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  // Wrapping +/-1 step; simultaneous up and down cancel out.
  function automatic logic [5:0] step_wrap(input logic [5:0] val, input logic [5:0] max_val,
                                           input logic up, input logic down);
    logic [5:0] res;
    res = val;
    if (up && !down) begin
      res = (val == max_val) ? 6'd0 : val + 6'd1;
    end else if (down && !up) begin
      res = (val == 6'd0) ? max_val : val - 6'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Load bus from the entry controller to the clock block.
interface time_set_ctrl_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;

  modport master (output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
  modport slave  (input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
endinterface

// File: rtl/time_set_ctrl_bin_to_bcd2.sv
// Combinational 0..59 binary to two-digit BCD.
module time_set_ctrl_bin_to_bcd2 #(
  parameter int unsigned TensW = 4
) (
  input  logic [5:0]       bin_i,
  output logic [TensW-1:0] tens_o,
  output logic [3:0]       units_o
);

  logic [3:0] tens;
  logic [3:0] tens_x10;

  // Tens digit by threshold compare; units computed mod 16 since the true remainder is < 10.
  always_comb begin
    if      (bin_i >= 6'd50) tens = 4'd5;
    else if (bin_i >= 6'd40) tens = 4'd4;
    else if (bin_i >= 6'd30) tens = 4'd3;
    else if (bin_i >= 6'd20) tens = 4'd2;
    else if (bin_i >= 6'd10) tens = 4'd1;
    else                     tens = 4'd0;
    tens_x10 = tens * 4'd10;
    units_o  = bin_i[3:0] - tens_x10;
    tens_o   = TensW'(tens);
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time/alarm entry controller feeding the clock block's load bus.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_HOLD = 10,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_set,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             sel_alarm,
  input  logic [1:0]       cur_h1,
  input  logic [3:0]       cur_h0,
  input  logic [3:0]       cur_m1,
  input  logic [3:0]       cur_m0,
  time_set_ctrl_if.master  ld_bus,
  output logic             editing,
  output logic             field_min
);

  localparam int unsigned HoldW = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
  localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LOAD_HOLD - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);

  state_e          state_q;
  target_e         target_q;
  logic [4:0]      hour_q;
  logic [5:0]      min_q;
  logic [HoldW-1:0] hold_q;
  logic [TmoW-1:0] tmo_q;
  logic            set_q, up_q, down_q;
  logic            editing_q, field_min_q, ld_time_q, ld_alarm_q;
  logic [1:0]      h_in1_q;
  logic [3:0]      h_in0_q, m_in1_q, m_in0_q;

  logic       set_e, up_e, down_e, any_e;
  logic [5:0] h_raw;
  logic [7:0] m_raw;
  logic [4:0] hour_seed;
  logic [5:0] min_seed;
  logic [1:0] h_tens;
  logic [3:0] h_units, m_tens, m_units;

  // Rising-edge detect and clamped seed from the running clock digits.
  always_comb begin
    set_e     = btn_set & ~set_q;
    up_e      = btn_up & ~up_q;
    down_e    = btn_down & ~down_q;
    any_e     = set_e | up_e | down_e;
    h_raw     = 6'(cur_h1) * 6'd10 + 6'(cur_h0);
    m_raw     = 8'(cur_m1) * 8'd10 + 8'(cur_m0);
    hour_seed = (h_raw > HOUR_MAX) ? HOUR_MAX[4:0] : h_raw[4:0];
    min_seed  = (m_raw > 8'(MIN_MAX)) ? MIN_MAX : m_raw[5:0];
  end

  time_set_ctrl_bin_to_bcd2 #(.TensW(2)) u_hour_bcd (
    .bin_i   ({1'b0, hour_q}),
    .tens_o  (h_tens),
    .units_o (h_units)
  );

  time_set_ctrl_bin_to_bcd2 #(.TensW(4)) u_min_bcd (
    .bin_i   (min_q),
    .tens_o  (m_tens),
    .units_o (m_units)
  );

  // Edit FSM with counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      target_q    <= TgtTime;
      hour_q      <= '0;
      min_q       <= '0;
      hold_q      <= '0;
      tmo_q       <= '0;
      set_q       <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      editing_q   <= 1'b0;
      field_min_q <= 1'b0;
      ld_time_q   <= 1'b0;
      ld_alarm_q  <= 1'b0;
      h_in1_q     <= '0;
      h_in0_q     <= '0;
      m_in1_q     <= '0;
      m_in0_q     <= '0;
    end else begin
      set_q       <= btn_set;
      up_q        <= btn_up;
      down_q      <= btn_down;
      editing_q   <= (state_q == StSetHour) || (state_q == StSetMin);
      field_min_q <= (state_q == StSetMin);
      // BCD presented one cycle after the binary value moves; static during LOAD.
      h_in1_q     <= h_tens;
      h_in0_q     <= h_units;
      m_in1_q     <= m_tens;
      m_in0_q     <= m_units;
      case (state_q)
        StIdle: begin
          if (set_e) begin
            hour_q   <= hour_seed;
            min_q    <= min_seed;
            target_q <= target_e'(sel_alarm);
            tmo_q    <= '0;
            state_q  <= StSetHour;
          end
        end
        StSetHour: begin
          if (set_e) begin
            tmo_q   <= '0;
            state_q <= StSetMin;
          end else if (any_e) begin
            tmo_q  <= '0;
            hour_q <= 5'(step_wrap({1'b0, hour_q}, HOUR_MAX, up_e, down_e));
          end else if (tmo_q == TmoLast) begin
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StSetMin: begin
          if (set_e) begin
            hold_q  <= '0;
            state_q <= StLoad;
            if (target_q == TgtAlarm) ld_alarm_q <= 1'b1;
            else                      ld_time_q  <= 1'b1;
          end else if (any_e) begin
            tmo_q <= '0;
            min_q <= step_wrap(min_q, MIN_MAX, up_e, down_e);
          end else if (tmo_q == TmoLast) begin
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StLoad: begin
          if (hold_q == HoldLast) begin
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            state_q    <= StIdle;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ld_bus.H_in1    = h_in1_q;
  assign ld_bus.H_in0    = h_in0_q;
  assign ld_bus.M_in1    = m_in1_q;
  assign ld_bus.M_in0    = m_in0_q;
  assign ld_bus.LD_time  = ld_time_q;
  assign ld_bus.LD_alarm = ld_alarm_q;
  assign editing         = editing_q;
  assign field_min       = field_min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed plus randomized bench for time_set_ctrl with a value-level reference model.
module tb_time_set_ctrl;

  localparam int LoadHold = 10;
  localparam int Timeout  = 1000;

  logic       clk = 1'b0;
  logic       reset, btn_set, btn_up, btn_down, sel_alarm;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0, cur_m1, cur_m0;
  logic       editing, field_min;

  time_set_ctrl_if ld_bus ();

  time_set_ctrl #(.LOAD_HOLD(LoadHold), .TIMEOUT(Timeout)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_set   (btn_set),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .sel_alarm (sel_alarm),
    .cur_h1    (cur_h1),
    .cur_h0    (cur_h0),
    .cur_m1    (cur_m1),
    .cur_m0    (cur_m0),
    .ld_bus    (ld_bus),
    .editing   (editing),
    .field_min (field_min)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_hour, m_min;
  int n_time, n_alarm, n_both;

  // Strobe-length monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (ld_bus.LD_time) n_time++;
    if (ld_bus.LD_alarm) n_alarm++;
    if (ld_bus.LD_time && ld_bus.LD_alarm) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bcd(input int h, input int m);
    return {18'd0, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [31:0] bus_val();
    return {18'd0, ld_bus.H_in1, ld_bus.H_in0, ld_bus.M_in1, ld_bus.M_in0};
  endfunction

  // One-cycle button pulse; returns after the BCD outputs have had time to follow.
  task automatic press(input logic s, input logic u, input logic d);
    @(negedge clk);
    btn_set = s; btn_up = u; btn_down = d;
    @(negedge clk);
    btn_set = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_op(input int op);
    if (op == 0) begin
      press(1'b0, 1'b1, 1'b0);
      if (field_min) m_min = (m_min + 1) % 60; else m_hour = (m_hour + 1) % 24;
    end else if (op == 1) begin
      press(1'b0, 1'b0, 1'b1);
      if (field_min) m_min = (m_min + 59) % 60; else m_hour = (m_hour + 23) % 24;
    end else begin
      press(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic seed(input string tag, input int h1, input int h0, input int m1, input int m0,
                      input logic alarm);
    cur_h1 = 2'(h1); cur_h0 = 4'(h0); cur_m1 = 4'(m1); cur_m0 = 4'(m0);
    sel_alarm = alarm;
    m_hour = h1 * 10 + h0;
    if (m_hour > 23) m_hour = 23;
    m_min = m1 * 10 + m0;
    if (m_min > 59) m_min = 59;
    press(1'b1, 1'b0, 1'b0);
    check({tag, "_seed"}, bus_val(), bcd(m_hour, m_min));
    check({tag, "_edit"}, {30'd0, editing, field_min}, 32'd2);
  endtask

  task automatic commit(input string tag, input logic alarm);
    n_time = 0; n_alarm = 0; n_both = 0;
    press(1'b1, 1'b0, 1'b0);
    repeat (LoadHold + 5) @(negedge clk);
    check({tag, "_ld_time"}, n_time, alarm ? 0 : LoadHold);
    check({tag, "_ld_alarm"}, n_alarm, alarm ? LoadHold : 0);
    check({tag, "_ld_both"}, n_both, 0);
    check({tag, "_held"}, bus_val(), bcd(m_hour, m_min));
    check({tag, "_idle"}, {31'd0, editing}, 0);
  endtask

  initial begin
    reset = 1'b1; btn_set = 1'b0; btn_up = 1'b0; btn_down = 1'b0; sel_alarm = 1'b0;
    cur_h1 = '0; cur_h0 = '0; cur_m1 = '0; cur_m0 = '0;
    repeat (3) @(negedge clk);
    check("reset_bus", bus_val(), 32'd0);
    check("reset_ld", {30'd0, ld_bus.LD_time, ld_bus.LD_alarm}, 0);
    check("reset_flags", {30'd0, editing, field_min}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic entry, step and commit to time.
    seed("t1", 1, 2, 3, 4, 1'b0);
    do_op(0); do_op(0);
    check("t1_hour", bus_val(), bcd(14, 34));
    press(1'b1, 1'b0, 1'b0);
    check("t1_field", {31'd0, field_min}, 1);
    repeat (5) do_op(1);
    check("t1_min", bus_val(), bcd(14, 29));
    commit("t1", 1'b0);

    // Hour and minute wrap at both ends.
    seed("t2", 2, 3, 5, 9, 1'b0);
    do_op(0);
    check("t2_hwrap_up", bus_val(), bcd(0, 59));
    do_op(1);
    check("t2_hwrap_dn", bus_val(), bcd(23, 59));
    press(1'b1, 1'b0, 1'b0);
    do_op(0);
    check("t2_mwrap_up", bus_val(), bcd(23, 0));
    do_op(1);
    check("t2_mwrap_dn", bus_val(), bcd(23, 59));
    commit("t2", 1'b0);

    // Target latched at entry; later sel_alarm changes are ignored.
    seed("t3", 0, 7, 1, 5, 1'b1);
    sel_alarm = 1'b0;
    do_op(1);
    press(1'b1, 1'b0, 1'b0);
    do_op(0);
    commit("t3", 1'b1);

    // Abandon by inactivity.
    n_time = 0; n_alarm = 0;
    seed("t4", 0, 9, 4, 5, 1'b0);
    repeat (Timeout - 10) @(negedge clk);
    check("t4_still_edit", {31'd0, editing}, 1);
    repeat (20) @(negedge clk);
    check("t4_timeout", {31'd0, editing}, 0);
    check("t4_no_ld", n_time + n_alarm, 0);
    check("t4_hold_vals", bus_val(), bcd(9, 45));

    // Conflicting edges in one cycle.
    seed("t5", 1, 0, 2, 0, 1'b0);
    do_op(2);
    check("t5_updn_hour", bus_val(), bcd(10, 20));
    press(1'b1, 1'b1, 1'b0);
    check("t5_set_up_field", {31'd0, field_min}, 1);
    check("t5_set_up_val", bus_val(), bcd(10, 20));
    do_op(2);
    check("t5_updn_min", bus_val(), bcd(10, 20));
    commit("t5", 1'b0);

    // Reset in the middle of LOAD.
    seed("t6", 1, 8, 3, 0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    n_time = 0; n_alarm = 0;
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_ld_drop", {30'd0, ld_bus.LD_time, ld_bus.LD_alarm}, 0);
    check("t6_bus_zero", bus_val(), 32'd0);
    check("t6_flags_zero", {30'd0, editing, field_min}, 0);
    reset = 1'b0;
    press(1'b0, 1'b1, 1'b0);
    check("t6_idle_ignores_up", bus_val(), 32'd0);
    check("t6_idle_flags", {30'd0, editing, field_min}, 0);
    check("t6_strobe_len", n_time + n_alarm, 3);

    // Randomized sessions, including out-of-range seed digits.
    for (int s = 0; s < 8; s++) begin
      logic alarm;
      alarm = 1'($urandom_range(0, 1));
      seed($sformatf("r%0d", s), $urandom_range(0, 3), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), alarm);
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) do_op($urandom_range(0, 2));
      check($sformatf("r%0d_hour", s), bus_val(), bcd(m_hour, m_min));
      press(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) do_op($urandom_range(0, 2));
      check($sformatf("r%0d_min", s), bus_val(), bcd(m_hour, m_min));
      commit($sformatf("r%0d", s), alarm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
